// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// gap counter width.
package bit_serializer_pkg;

  // Gap counter width; GAP parameter range is 0..15.
  localparam int GAP_W = 4;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_GAP    = 2'd3;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bus for the bit serializer.
// master: word producer plus serial consumer (testbench / upstream logic).
// slave : the serializer itself.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             a;
  logic             a_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, a, a_valid, frame_start, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, a, a_valid, frame_start, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Bit serializer: accepts parallel words into a one-deep holding register
// and shifts them out MSB first on a registered serial output, with an
// optional forced idle gap between frames.
// Optional feature: define SER_PARITY_EN to append an even-parity bit
// after the LSB of every frame.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH);
  localparam logic [GAP_W-1:0]  GAP_LEN  = GAP_W'(GAP);

  // Registered state
  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   hold_q,      hold_d;
  logic               hold_full_q, hold_full_d;
  logic               ready_q,     ready_d;
  logic [WIDTH-1:0]   shreg_q,     shreg_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [GAP_W-1:0]   gap_q,       gap_d;
  logic               a_q,         a_d;
  logic               a_valid_q,   a_valid_d;
  logic               fs_q,        fs_d;
`ifdef SER_PARITY_EN
  logic               par_q,       par_d;
`endif

  logic               accept;
  logic               load;
  logic               frame_done;

  // din_ready is a flop output, so acceptance never depends combinationally
  // on din_valid feeding back into din_ready.
  assign accept = bus.din_valid & ready_q;

  // Next-state logic: FSM, shifter, counters, holding register.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    a_d        = 1'b0;
    a_valid_d  = 1'b0;
    fs_d       = 1'b0;
    load       = 1'b0;
    frame_done = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          // Emit the next bit; the counter stops at WIDTH and never wraps.
          a_d       = shreg_q[WIDTH-1];
          a_valid_d = 1'b1;
          shreg_d   = shreg_q << 1;
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
`ifdef SER_PARITY_EN
          state_d   = ST_PARITY;
          a_d       = par_q;
          a_valid_d = 1'b1;
`else
          frame_done = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        frame_done = 1'b1;
      end
`endif
      ST_GAP: begin
        // gap_q counts idle cycles already shown; stops at GAP_LEN.
        if (gap_q != GAP_LEN) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // End of frame: forced gap, seamless reload, or back to idle.
    if (frame_done) begin
      if (GAP > 0) begin
        state_d = ST_GAP;
        gap_d   = GAP_W'(1);
      end else if (hold_full_q) begin
        load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Start a frame from the holding register; MSB goes out on this edge.
    if (load) begin
      state_d   = ST_SHIFT;
      a_d       = hold_q[WIDTH-1];
      a_valid_d = 1'b1;
      fs_d      = 1'b1;
      shreg_d   = hold_q << 1;
      cnt_d     = CNT_W'(1);
`ifdef SER_PARITY_EN
      par_d     = ^hold_q;
`endif
    end

    // Holding register may refill on the same edge it is unloaded.
    hold_full_d = accept | (hold_full_q & ~load);
    hold_d      = accept ? bus.din : hold_q;
    ready_d     = ~hold_full_d;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the holding register and shifter are data storage, but they
      // are cleared here so a reset discards any partial or pending frame.
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      a_q         <= 1'b0;
      a_valid_q   <= 1'b0;
      fs_q        <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      a_q         <= a_d;
      a_valid_q   <= a_valid_d;
      fs_q        <= fs_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign bus.din_ready   = ready_q;
  assign bus.a           = a_q;
  assign bus.a_valid     = a_valid_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = (state_q != ST_IDLE) | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer: one instance with GAP=0 and one
// with GAP=2. Expected streams are hand-written word constants.
// Build with SER_PARITY_EN defined to also exercise the parity bit.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 8 + PB;

  logic clk = 1'b0;
  logic reset0;
  logic reset2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) bus0 ();
  bit_serializer_if #(.WIDTH(8)) bus2 ();

  bit_serializer #(.WIDTH(8), .GAP(0)) dut0 (.clk(clk), .reset(reset0), .bus(bus0));
  bit_serializer #(.WIDTH(8), .GAP(2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit idx of a frame carrying word w: MSB first, then parity at idx 8.
  function automatic logic frame_bit(input logic [7:0] w, input int idx);
    if (idx < 8) return w[7-idx];
    return ^w;
  endfunction

  initial begin
    reset0 = 1'b1;
    reset2 = 1'b1;
    bus0.din = '0;
    bus0.din_valid = 1'b0;
    bus2.din = '0;
    bus2.din_valid = 1'b0;

    // Reset held three cycles: serial output quiet, not ready.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_a", bus0.a, 0);
      check("rst_a_valid", bus0.a_valid, 0);
      check("rst_ready", bus0.din_ready, 0);
      check("rst_busy", bus0.busy, 0);
    end
    reset0 = 1'b0;
    reset2 = 1'b0;
    tick();
    check("post_rst_ready", bus0.din_ready, 1);
    check("post_rst_ready_g2", bus2.din_ready, 1);
    check("post_rst_a_valid", bus0.a_valid, 0);

    // Single word 8'hC0: first bit one cycle after acceptance.
    bus0.din = 8'hC0;
    bus0.din_valid = 1'b1;
    tick();
    check("single_ready_full", bus0.din_ready, 0);
    check("single_not_yet", bus0.a_valid, 0);
    check("single_busy", bus0.busy, 1);
    bus0.din_valid = 1'b0;
    bus0.din = 8'h00;
    for (int i = 0; i < FL; i++) begin
      tick();
      check("single_bit", bus0.a, frame_bit(8'hC0, i));
      check("single_valid", bus0.a_valid, 1);
      check("single_fs", bus0.frame_start, (i == 0) ? 1 : 0);
    end
    tick();
    check("single_end_valid", bus0.a_valid, 0);
    check("single_end_a", bus0.a, 0);
    check("single_end_busy", bus0.busy, 0);

    // Back-to-back C0 then 60 with GAP=0: contiguous stream.
    bus0.din = 8'hC0;
    bus0.din_valid = 1'b1;
    tick();
    bus0.din = 8'h60;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      check("b2b_bit", bus0.a, (i < FL) ? frame_bit(8'hC0, i) : frame_bit(8'h60, i - FL));
      check("b2b_valid", bus0.a_valid, 1);
      check("b2b_fs", bus0.frame_start, (i == 0 || i == FL) ? 1 : 0);
      if (i == 0) check("b2b_ready_empty", bus0.din_ready, 1);
      if (i == 1) begin
        check("b2b_ready_full", bus0.din_ready, 0);
        bus0.din_valid = 1'b0;
      end
      if (i == 4) check("b2b_ready_still_full", bus0.din_ready, 0);
      if (i == FL) check("b2b_ready_after_reload", bus0.din_ready, 1);
    end
    tick();
    check("b2b_end_valid", bus0.a_valid, 0);
    check("b2b_end_busy", bus0.busy, 0);

    // Reset mid-frame of 8'hFF with a second word held.
    bus0.din = 8'hFF;
    bus0.din_valid = 1'b1;
    tick();
    tick();
    tick();
    bus0.din_valid = 1'b0;
    tick();
    tick();
    check("mid_busy_before", bus0.busy, 1);
    check("mid_bit3", bus0.a, 1);
    reset0 = 1'b1;
    tick();
    check("mid_rst_a", bus0.a, 0);
    check("mid_rst_valid", bus0.a_valid, 0);
    check("mid_rst_busy", bus0.busy, 0);
    check("mid_rst_ready", bus0.din_ready, 0);
    reset0 = 1'b0;
    tick();
    check("mid_ready_back", bus0.din_ready, 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus0.a_valid !== 1'b0 || bus0.a !== 1'b0) seen++;
      end
      check("mid_no_more_bits", seen, 0);
    end

    // GAP=2 instance: A5 then 3C with exactly two idle cycles between.
    bus2.din = 8'hA5;
    bus2.din_valid = 1'b1;
    tick();
    bus2.din = 8'h3C;
    for (int i = 0; i < FL; i++) begin
      tick();
      check("gap_f1_bit", bus2.a, frame_bit(8'hA5, i));
      check("gap_f1_valid", bus2.a_valid, 1);
      if (i == 1) begin
        check("gap_ready_full", bus2.din_ready, 0);
        bus2.din_valid = 1'b0;
      end
    end
    for (int g = 0; g < 2; g++) begin
      tick();
      check("gap_idle_valid", bus2.a_valid, 0);
      check("gap_idle_a", bus2.a, 0);
      check("gap_idle_fs", bus2.frame_start, 0);
      check("gap_idle_busy", bus2.busy, 1);
    end
    for (int i = 0; i < FL; i++) begin
      tick();
      check("gap_f2_bit", bus2.a, frame_bit(8'h3C, i));
      check("gap_f2_valid", bus2.a_valid, 1);
      check("gap_f2_fs", bus2.frame_start, (i == 0) ? 1 : 0);
    end
    for (int g = 0; g < 2; g++) begin
      tick();
      check("gap_tail_valid", bus2.a_valid, 0);
    end
    tick();
    check("gap_tail_busy", bus2.busy, 0);

`ifdef SER_PARITY_EN
    // Parity: 8'h07 -> 00000111 then parity bit 1, nine valid bits.
    begin
      logic [8:0] exp9;
      exp9 = 9'b000001111;
      bus0.din = 8'h07;
      bus0.din_valid = 1'b1;
      tick();
      bus0.din_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        tick();
        check("par_bit", bus0.a, exp9[8-i]);
        check("par_valid", bus0.a_valid, 1);
      end
      tick();
      check("par_len_end", bus0.a_valid, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width (2..32).
REQ-002 SHALL have parameter GAP, default 0, forced idle cycles between consecutive frames (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a valid word.
REQ-007 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port a  output  1  registered serial bit stream, MSB first; feeds the downstream pattern detector's a input.
REQ-009 SHALL have port a_valid  output  1  a carries a frame bit (not idle/gap).
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse, high with the first bit of each frame.
REQ-011 SHALL have port busy  output  1  shifter or holding register occupied, or gap in progress.

Function
REQ-012 SHALL accept a word on any rising edge where din_valid and din_ready are both 1.
REQ-013 SHALL buffer accepted words in one holding register; din_ready = holding register empty, registered, with no combinational path from din_valid.
REQ-014 SHALL implement FSM states IDLE, SHIFT, PARITY, and GAP; PARITY is reachable only when SER_PARITY_EN is defined.
REQ-015 SHALL go IDLE->SHIFT on the edge after the holding register becomes full, loading the shifter and emptying the holding register in the same edge.
REQ-016 SHALL drive the first (MSB) bit on a exactly one cycle after the accepting edge when IDLE; latency = 1 clk.
REQ-017 SHALL drive one bit per cycle for WIDTH cycles in SHIFT, a_valid=1 throughout.
REQ-018 SHALL, on the last bit, go to PARITY, or to GAP if GAP>0, or else reload directly from the holding register into SHIFT if it is full, or else go to IDLE.
REQ-019 SHALL, with GAP=0 and a full holding register, stream frames back-to-back with no idle cycle.
REQ-020 SHALL, in GAP, hold a=0 and a_valid=0 for exactly GAP cycles, then go to SHIFT if the holding register is full, else IDLE.
REQ-021 SHALL drive a=0, a_valid=0, and frame_start=0 whenever in IDLE or GAP.
REQ-022 SHALL treat simultaneous acceptance and shifter reload as legal: the holding register refills on the same edge it empties.
REQ-023 SHALL ignore din whenever din_ready=0; the producer holds data.
REQ-024 SHALL size the bit counter as $clog2(WIDTH+1) bits and the gap counter as 4 bits, with no wrap beyond their terminal values.

Reset
REQ-025 SHALL, while reset=1 at an edge, force FSM=IDLE, clear the holding register and shifter, and set a=0, a_valid=0, frame_start=0, busy=0, din_ready=0.
REQ-026 SHALL set din_ready=1 on the first edge after reset deasserts.
REQ-027 SHALL, on reset mid-frame, discard the partial frame and the held word; no remaining bits are emitted.

Configuration
REQ-028 SHALL, with SER_PARITY_EN defined, append one even-parity bit (XOR of the word) after the LSB, frame length WIDTH+1, a_valid=1.
REQ-029 SHALL, without SER_PARITY_EN, use frame length WIDTH and exclude PARITY state logic entirely.

Structure
REQ-030 SHALL place the FSM state enum and the GAP_W=4 constant in package bit_serializer_pkg.
REQ-031 SHALL contain no sub-module; the parity XOR is inline logic.

Verification
REQ-032 SHALL verify: reset held 3 cycles -> a=0, a_valid=0, din_ready=0 throughout; din_ready=1 on the next cycle.
REQ-033 SHALL verify: WIDTH=8, din=8'hC0 accepted at edge N -> a=1,1,0,0,0,0,0,0 at cycles N+1..N+8, frame_start at N+1 only.
REQ-034 SHALL verify: GAP=0, words 8'hC0 then 8'h60 presented continuously -> 16 contiguous valid bits 11000000 01100000, din_ready low while the holding register is full.
REQ-035 SHALL verify: GAP=2, two words -> exactly 2 cycles with a_valid=0, a=0 between frames.
REQ-036 SHALL verify: reset asserted at bit 4 of 8'hFF with the holding register full -> next cycle a=0, a_valid=0, busy=0, and no further bits emitted.
REQ-037 SHALL verify: with SER_PARITY_EN defined, din=8'h07 -> bits 00000111 followed by parity bit 1; frame length 9.
